// File: rtl/pdm_cic_decimator_if.sv
// PDM input / PCM sample handshake bundle for pdm_cic_decimator.
// master = decimator side, slave = PDM source + sample consumer.
interface pdm_cic_decimator_if;
  logic               pdm_in;
  logic               pdm_en;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               sample_ready;
  logic               overflow;

  modport master (
    input  pdm_in,
    input  pdm_en,
    input  sample_ready,
    output sample_out,
    output sample_valid,
    output overflow
  );

  modport slave (
    output pdm_in,
    output pdm_en,
    output sample_ready,
    input  sample_out,
    input  sample_valid,
    input  overflow
  );
endinterface

// File: rtl/pdm_cic_decimator.sv
// 1-bit PDM to 16-bit PCM, 3rd-order CIC, decimate by 2^LOG2_DECIM.
// Optional DC blocker after saturation: define DC_BLOCK_EN.
module pdm_cic_decimator #(
  parameter int LOG2_DECIM = 6
) (
  input  logic clk,
  input  logic rst_n,
  pdm_cic_decimator_if.master bus
);

  localparam int W     = 3*LOG2_DECIM + 2;
  localparam int SHIFT = 3*LOG2_DECIM - 15;

  localparam logic signed [W-1:0] P_MAX = W'(32767);
  localparam logic signed [W-1:0] P_MIN = W'(-32768);

  logic                  r_sync1;
  logic                  r_sync2;
  logic signed [W-1:0]   r_int1;
  logic signed [W-1:0]   r_int2;
  logic signed [W-1:0]   r_int3;
  logic [LOG2_DECIM-1:0] r_cnt;
  logic                  r_frame;
  logic signed [W-1:0]   r_dly1;
  logic signed [W-1:0]   r_dly2;
  logic signed [W-1:0]   r_dly3;
  logic signed [15:0]    r_out;
  logic                  r_vld;
  logic                  r_ovf;

  logic signed [W-1:0]   w_x;
  logic signed [W-1:0]   w_c1;
  logic signed [W-1:0]   w_c2;
  logic signed [W-1:0]   w_c3;
  logic signed [W-1:0]   w_shr;
  logic signed [15:0]    w_sat;
  logic signed [15:0]    w_new_val;
  logic                  w_new_stb;

  // pdm_s=1 -> +1, pdm_s=0 -> -1
  assign w_x = r_sync2 ? {{(W-1){1'b0}}, 1'b1}
                       : {W{1'b1}};

  // Combs read the integrator output settled by the frame edge
  assign w_c1  = r_int3 - r_dly1;
  assign w_c2  = w_c1 - r_dly2;
  assign w_c3  = w_c2 - r_dly3;
  assign w_shr = w_c3 >>> SHIFT;

  // Two-flop synchronizer for the asynchronous PDM pin
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.pdm_in;
      r_sync2 <= r_sync1;
    end
  end

  // Integrators and decimation counter advance on each strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_int1  <= '0;
      r_int2  <= '0;
      r_int3  <= '0;
      r_cnt   <= '0;
      r_frame <= 1'b0;
    end else begin
      r_frame <= bus.pdm_en & (&r_cnt);
      if (bus.pdm_en) begin
        r_int1 <= r_int1 + w_x;
        r_int2 <= r_int2 + r_int1;
        r_int3 <= r_int3 + r_int2;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  // Comb delay line moves once per output frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dly1 <= '0;
      r_dly2 <= '0;
      r_dly3 <= '0;
    end else if (r_frame) begin
      r_dly1 <= r_int3;
      r_dly2 <= w_c1;
      r_dly3 <= w_c2;
    end
  end

  // Clamp the scaled comb output to 16-bit signed
  always_comb begin
    w_sat = w_shr[15:0];
    if (w_shr > P_MAX)
      w_sat = 16'sh7fff;
    else if (w_shr < P_MIN)
      w_sat = 16'sh8000;
  end

`ifdef DC_BLOCK_EN
  logic signed [15:0] r_dc_xp;
  logic signed [17:0] r_dc_y;
  logic               r_dc_vld;
  logic signed [17:0] w_dc_yshr;
  logic signed [19:0] w_dc_sum;
  logic signed [17:0] w_dc_y;

  assign w_dc_yshr = r_dc_y >>> 8;
  assign w_dc_sum  = {{4{w_sat[15]}}, w_sat}
                   - {{4{r_dc_xp[15]}}, r_dc_xp}
                   + {{2{r_dc_y[17]}}, r_dc_y}
                   - {{2{w_dc_yshr[17]}}, w_dc_yshr};
  assign w_new_stb = r_dc_vld;

  // Keep the blocker state inside its 18-bit range
  always_comb begin
    w_dc_y = w_dc_sum[17:0];
    if (w_dc_sum > 20'sd131071)
      w_dc_y = 18'sh1ffff;
    else if (w_dc_sum < -20'sd131072)
      w_dc_y = 18'sh20000;
  end

  // Blocker output narrowed to 16 bits for the holding register
  always_comb begin
    w_new_val = r_dc_y[15:0];
    if (r_dc_y > 18'sd32767)
      w_new_val = 16'sh7fff;
    else if (r_dc_y < -18'sd32768)
      w_new_val = 16'sh8000;
  end

  // One blocker step per CIC sample, one extra clk of latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dc_xp  <= '0;
      r_dc_y   <= '0;
      r_dc_vld <= 1'b0;
    end else begin
      r_dc_vld <= r_frame;
      if (r_frame) begin
        r_dc_xp <= w_sat;
        r_dc_y  <= w_dc_y;
      end
    end
  end
`else
  assign w_new_val = w_sat;
  assign w_new_stb = r_frame;
`endif

  // Single holding register; a new sample overwrites an unread one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out <= '0;
      r_vld <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_new_stb) begin
      r_out <= w_new_val;
      r_vld <= 1'b1;
      if (r_vld && !bus.sample_ready)
        r_ovf <= 1'b1;
    end else if (r_vld && bus.sample_ready) begin
      r_vld <= 1'b0;
    end
  end

  assign bus.sample_out   = r_out;
  assign bus.sample_valid = r_vld;
  assign bus.overflow     = r_ovf;

endmodule

// File: doc/pdm_cic_decimator.md
Name: pdm_cic_decimator

Overview:
- Receive-side counterpart of the sigma-delta PDM audio output: converts a 1-bit PDM stream (e.g. an external PDM microphone on a uio pin) into 16-bit signed PCM samples.
- Uses a 3rd-order CIC decimator, decimating by 2^LOG2_DECIM.
- Presents samples on a valid/ready interface backed by a single holding register, with a sticky overflow flag.

Parameters:
- LOG2_DECIM, 6, log2 of the decimation ratio R. Legal range 5..8.
- W (localparam), 3*LOG2_DECIM+2, width of the CIC integrator and comb datapath.
- SHIFT (localparam), 3*LOG2_DECIM-15, right shift applied before saturation to 16 bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- pdm_in  in  1  raw asynchronous PDM data bit.
- pdm_en  in  1  one-clk strobe; the synchronized bit is consumed when high.
- sample_out  out  16  signed PCM sample.
- sample_valid  out  1  sample_out holds an unconsumed sample.
- sample_ready  in  1  consumer accepts when sample_valid & sample_ready.
- overflow  out  1  sticky: a sample was overwritten before it was accepted.

Behaviour:
- Reset (already decided): rst_n, synchronous, active-low; clock clk.
- On reset, all of the following are zeroed: synchronizer flops, integrators, comb delay registers, decimation counter, sample_out, sample_valid, overflow. Reset mid-frame discards the partial frame; the counter restarts at 0.
- Input path: pdm_in passes through a 2-flop synchronizer giving pdm_s. A bit at pdm_in in cycle t is consumed by a pdm_en strobe in cycle t+2 or later.
- Input mapping: pdm_s=1 maps to +1, pdm_s=0 maps to -1 (W-bit two's complement).
- Integrators: three cascaded W-bit registers, updated only on pdm_en. Arithmetic is modulo 2^W; wrap-around is intentional and must not saturate.
- Decimation counter: LOG2_DECIM bits, incremented on each pdm_en. When it wraps from R-1 to 0, a frame-done pulse is registered.
- Comb stage: in the cycle after frame-done, three cascaded combs (y = x - x_prev, differential delay 1, modulo 2^W) are evaluated combinationally from the last integrator output, and the comb delay registers update.
- Output scaling: result r is in [-2^(3*LOG2_DECIM), +2^(3*LOG2_DECIM)]. Output is r >>> SHIFT (arithmetic), saturated to [-32768, 32767]. With the defaults, full scale +1 gives 32768, which saturates to 32767.
- Latency: sample_valid rises 2 clk after the pdm_en cycle that completes the frame.
- Warm-up: the first 3 samples after reset are filter transients. Samples from the 4th onward are steady state.
- Handshake: sample_valid stays high until a cycle with sample_ready=1. sample_out is stable while sample_valid=1, unless overwritten.
- New sample, holding register empty or accepted in the same cycle: load sample_out, sample_valid=1, no overflow.
- New sample, sample_valid=1 and sample_ready=0: sample_out is overwritten with the newest sample, sample_valid stays 1, overflow is set to 1.
- overflow clears only on reset.
- pdm_en may be held high continuously (one bit per clk) or strobed at any lower rate. No bits are lost at any strobe rate.

Optional Feature:
- Macro DC_BLOCK_EN.
- When defined: a DC blocker is inserted after saturation: y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 8). It uses 18-bit internal state; the output is saturated to 16 bits. This adds 1 clk of latency (sample_valid rises 3 clk after the completing pdm_en). State resets to 0.
- When undefined: the saturated CIC output is presented directly, with 2-clk latency. No DC-blocker registers exist.

Test Plan:
- Reset -> sample_out=0, sample_valid=0, overflow=0. Hold rst_n low for 3 clk mid-frame, then release -> counter restarts; the next sample appears exactly 64 pdm_en strobes after release (+2 clk).
- pdm_in=1 constant, pdm_en=1 every clk, sample_ready=1 -> one sample_valid pulse per 64 clk. Samples 4 onward = 32767. pdm_in=0 constant -> -32768. Build with DC_BLOCK_EN: output decays toward 0.
- pdm_in alternating 1,0,1,0 -> samples 4 onward = 0. Pattern 1,1,1,0 repeating -> samples 4 onward = 16384.
- sample_ready=0 across two frames -> after the second frame overflow=1, sample_valid=1, sample_out = second sample. Then raise sample_ready for 1 clk -> sample_valid=0, overflow stays 1.
- sample_ready=1 in the exact cycle a new sample is produced while sample_valid=1 -> sample_valid stays 1 with the new value, overflow=0.
- pdm_en every 4th clk -> samples every 256 clk with values identical to the continuous-strobe run. Integrator wrap exercised by running more than 4096 bits of all-ones without error.
